// File: rtl/lsu_pkg.sv
// lsu_pkg: shared FSM state, funct3 codes and memory command encodings for the load/store unit.
package lsu_pkg;
    localparam int MEM_BYTES_DEF = 524288;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CAPTURE, S_RESP} state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] RW_IDLE = 4'b0000;
    localparam logic [3:0] RW_LB   = 4'b1000;
    localparam logic [3:0] RW_LH   = 4'b1001;
    localparam logic [3:0] RW_LW   = 4'b1010;
    localparam logic [3:0] RW_LBU  = 4'b1100;
    localparam logic [3:0] RW_LHU  = 4'b1101;
    localparam logic [3:0] RW_SB   = 4'b1011;
    localparam logic [3:0] RW_SH   = 4'b1110;
    localparam logic [3:0] RW_SW   = 4'b1111;
endpackage

// File: rtl/lsu_cmd_encode.sv
// lsu_cmd_encode: maps is_store/funct3/addr to memory command, access size and fault.
// Alignment faults only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_cmd_encode
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEF
) (
    input  logic              is_store,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    output logic [3:0]        rw_en,
    output logic [2:0]        size,
    output logic              fault
);
    logic              bad_op;
    logic              misalign;
    logic [ADDR_W:0]   last;

    always_comb begin
        rw_en  = RW_IDLE;
        size   = 3'd1;
        bad_op = 1'b0;
        case ({is_store, funct3})
            {1'b0, F3_B}:  rw_en = RW_LB;
            {1'b0, F3_H}:  begin rw_en = RW_LH; size = 3'd2; end
            {1'b0, F3_W}:  begin rw_en = RW_LW; size = 3'd4; end
            {1'b0, F3_BU}: rw_en = RW_LBU;
            {1'b0, F3_HU}: begin rw_en = RW_LHU; size = 3'd2; end
            {1'b1, F3_B}:  rw_en = RW_SB;
            {1'b1, F3_H}:  begin rw_en = RW_SH; size = 3'd2; end
            {1'b1, F3_W}:  begin rw_en = RW_SW; size = 3'd4; end
            default:       bad_op = 1'b1;
        endcase
        // one extra bit so accesses that wrap past the top of the address space still fault
        last = {1'b0, addr} + {{(ADDR_W-2){1'b0}}, size} - (ADDR_W+1)'(1);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (size == 3'd2 && addr[0]) || (size == 3'd4 && addr[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        fault = bad_op || misalign || (last >= (ADDR_W+1)'(MEM_BYTES));
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding memory-stage front end between execute and data memory.
// Optional alignment trapping via LSU_MISALIGN_TRAP_EN (see lsu_cmd_encode).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int TAG_W     = 5
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_IS_STORE,
    input  logic [2:0]        REQ_FUNCT3,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [ADDR_W-1:0] REQ_WDATA,
    input  logic [TAG_W-1:0]  REQ_TAG,
    output logic [3:0]        MEM_RW_EN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [ADDR_W-1:0] MEM_WDATA,
    input  logic [ADDR_W-1:0] MEM_RDATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [ADDR_W-1:0] RSP_DATA,
    output logic [TAG_W-1:0]  RSP_TAG,
    output logic              RSP_IS_LOAD,
    output logic              RSP_FAULT
);
    state_e              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   data_q, data_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                is_load_q, is_load_d;
    logic                fault_q, fault_d;
    logic [3:0]          enc_rw_en;
    logic                enc_fault;

    lsu_cmd_encode #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) u_enc (
        .is_store (REQ_IS_STORE),
        .funct3   (REQ_FUNCT3),
        .addr     (REQ_ADDR),
        .rw_en    (enc_rw_en),
        .size     (),
        .fault    (enc_fault)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        data_d    = data_q;
        tag_d     = tag_q;
        is_load_d = is_load_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: if (REQ_VALID) begin
                cmd_d     = enc_rw_en;
                addr_d    = REQ_ADDR;
                wdata_d   = REQ_WDATA;
                tag_d     = REQ_TAG;
                is_load_d = !REQ_IS_STORE;
                fault_d   = enc_fault;
                data_d    = '0;
                state_d   = enc_fault ? S_RESP : S_ACCESS;
            end
            S_ACCESS:  state_d = is_load_q ? S_CAPTURE : S_RESP;
            S_CAPTURE: begin
                data_d  = MEM_RDATA;
                state_d = S_RESP;
            end
            S_RESP:    if (RSP_READY) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= S_IDLE;
            cmd_q     <= RW_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            data_q    <= '0;
            tag_q     <= '0;
            is_load_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            data_q    <= data_d;
            tag_q     <= tag_d;
            is_load_q <= is_load_d;
            fault_q   <= fault_d;
        end
    end

    // command decoded from state so it vanishes the instant reset asserts
    assign MEM_RW_EN   = (state_q == S_ACCESS) ? cmd_q : RW_IDLE;
    assign MEM_ADDR    = addr_q;
    assign MEM_WDATA   = wdata_q;
    assign REQ_READY   = (state_q == S_IDLE);
    assign RSP_VALID   = (state_q == S_RESP);
    assign RSP_DATA    = data_q;
    assign RSP_TAG     = tag_q;
    assign RSP_IS_LOAD = is_load_q;
    assign RSP_FAULT   = fault_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench with a byte-addressed registered-read memory model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [4:0]  req_tag = '0;
    logic [3:0]  mem_rw_en;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_is_load, rsp_fault;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic        e_st = 1'b0;
    logic [2:0]  e_f3 = '0;
    logic [3:0]  e_rw;
    logic [2:0]  e_size;
    logic        e_fault;
    logic [7:0]  mem [0:4095];
    int          n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .CLK(clk), .RESET_N(rst_n), .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_IS_STORE(req_is_store), .REQ_FUNCT3(req_funct3), .REQ_ADDR(req_addr),
        .REQ_WDATA(req_wdata), .REQ_TAG(req_tag), .MEM_RW_EN(mem_rw_en), .MEM_ADDR(mem_addr),
        .MEM_WDATA(mem_wdata), .MEM_RDATA(mem_rdata), .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready),
        .RSP_DATA(rsp_data), .RSP_TAG(rsp_tag), .RSP_IS_LOAD(rsp_is_load), .RSP_FAULT(rsp_fault)
    );

    lsu_cmd_encode u_enc (
        .is_store(e_st), .funct3(e_f3), .addr(32'h100), .rw_en(e_rw), .size(e_size), .fault(e_fault)
    );

    // memory: little-endian bytes, registered read data already sign/zero extended
    always @(posedge clk) begin
        logic [11:0] a;
        a = mem_addr[11:0];
        case (mem_rw_en)
            4'b1011: mem[a] <= mem_wdata[7:0];
            4'b1110: begin mem[a] <= mem_wdata[7:0]; mem[a+12'd1] <= mem_wdata[15:8]; end
            4'b1111: begin
                mem[a] <= mem_wdata[7:0];          mem[a+12'd1] <= mem_wdata[15:8];
                mem[a+12'd2] <= mem_wdata[23:16];  mem[a+12'd3] <= mem_wdata[31:24];
            end
            4'b1000: mem_rdata <= {{24{mem[a][7]}}, mem[a]};
            4'b1100: mem_rdata <= {24'd0, mem[a]};
            4'b1001: mem_rdata <= {{16{mem[a+12'd1][7]}}, mem[a+12'd1], mem[a]};
            4'b1101: mem_rdata <= {16'd0, mem[a+12'd1], mem[a]};
            4'b1010: mem_rdata <= {mem[a+12'd3], mem[a+12'd2], mem[a+12'd1], mem[a]};
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] tag);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
        req_addr = addr; req_wdata = wd; req_tag = tag;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic await(input int lat, input logic [3:0] cmd, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] data, input logic fault,
                         input logic [4:0] tag, input logic is_load);
        int k = 0, n_cmd = 0;
        logic [3:0] seen = 4'd0;
        do begin
            @(negedge clk);
            k++;
            if (mem_rw_en != 4'd0) begin
                n_cmd++;
                seen = mem_rw_en;
                chk("mem_addr", mem_addr, addr);
                chk("mem_wdata", mem_wdata, wd);
            end
        end while (!rsp_valid && k < 12);
        chk("latency", 32'(k), 32'(lat));
        chk("cmd_cycles", 32'(n_cmd), fault ? 32'd0 : 32'd1);
        chk("cmd", 32'(seen), 32'(cmd));
        chk("rsp_data", rsp_data, data);
        chk("rsp_fault", 32'(rsp_fault), 32'(fault));
        chk("rsp_tag", 32'(rsp_tag), 32'(tag));
        chk("rsp_is_load", 32'(rsp_is_load), 32'(is_load));
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] tag, input int lat,
                      input logic [3:0] cmd, input logic [31:0] data, input logic fault);
        issue(st, f3, addr, wd, tag);
        await(lat, cmd, addr, wd, data, fault, tag, !st);
        ack();
    endtask

    typedef struct { logic st; logic [2:0] f3; logic [3:0] rw; logic [2:0] sz; } enc_t;
    enc_t enc_tab [8] = '{
        '{1'b0, 3'b000, 4'b1000, 3'd1}, '{1'b0, 3'b001, 4'b1001, 3'd2},
        '{1'b0, 3'b010, 4'b1010, 3'd4}, '{1'b0, 3'b100, 4'b1100, 3'd1},
        '{1'b0, 3'b101, 4'b1101, 3'd2}, '{1'b1, 3'b000, 4'b1011, 3'd1},
        '{1'b1, 3'b001, 4'b1110, 3'd2}, '{1'b1, 3'b010, 4'b1111, 3'd4}
    };

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'd0;
        foreach (enc_tab[i]) begin
            e_st = enc_tab[i].st; e_f3 = enc_tab[i].f3;
            #1;
            chk("enc_rw", 32'(e_rw), 32'(enc_tab[i].rw));
            chk("enc_size", 32'(e_size), 32'(enc_tab[i].sz));
            chk("enc_fault", 32'(e_fault), 32'd0);
        end
        e_st = 1'b1; e_f3 = 3'b100;
        #1 chk("enc_bad_store", 32'(e_fault), 32'd1);

        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mem_rw_en", 32'(mem_rw_en), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_is_load", 32'(rsp_is_load), 32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        op(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 5'd1, 2, 4'b1111, 32'h0, 1'b0);
        op(1'b0, 3'b010, 32'h100, 32'h0, 5'd2, 3, 4'b1010, 32'hDEADBEEF, 1'b0);
        op(1'b1, 3'b000, 32'h200, 32'h12345680, 5'd3, 2, 4'b1011, 32'h0, 1'b0);
        op(1'b0, 3'b000, 32'h200, 32'h0, 5'd4, 3, 4'b1000, 32'hFFFFFF80, 1'b0);
        op(1'b0, 3'b100, 32'h200, 32'h0, 5'd5, 3, 4'b1100, 32'h00000080, 1'b0);
        op(1'b1, 3'b001, 32'h210, 32'h0000BEEF, 5'd6, 2, 4'b1110, 32'h0, 1'b0);
        op(1'b0, 3'b001, 32'h210, 32'h0, 5'd7, 3, 4'b1001, 32'hFFFFBEEF, 1'b0);
        op(1'b0, 3'b101, 32'h210, 32'h0, 5'd8, 3, 4'b1101, 32'h0000BEEF, 1'b0);
        op(1'b0, 3'b011, 32'h100, 32'h0, 5'd9, 1, 4'b0000, 32'h0, 1'b1);
        op(1'b0, 3'b010, 32'h0007FFFE, 32'h0, 5'd10, 1, 4'b0000, 32'h0, 1'b1);
        op(1'b0, 3'b010, 32'h0007FFFC, 32'h0, 5'd11, 3, 4'b1010, 32'h0, 1'b0);
        op(1'b0, 3'b000, 32'hFFFFFFFE, 32'h0, 5'd12, 1, 4'b0000, 32'h0, 1'b1);
        op(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd13, 1, 4'b0000, 32'h0, 1'b1);
        op(1'b1, 3'b011, 32'h100, 32'h0, 5'd14, 1, 4'b0000, 32'h0, 1'b1);
`ifdef LSU_MISALIGN_TRAP_EN
        op(1'b0, 3'b010, 32'h102, 32'h0, 5'd15, 1, 4'b0000, 32'h0, 1'b1);
`else
        op(1'b0, 3'b010, 32'h102, 32'h0, 5'd15, 3, 4'b1010, 32'h0000DEAD, 1'b0);
`endif

        // back-pressure with a second request waiting
        issue(1'b0, 3'b010, 32'h100, 32'h0, 5'd16);
        await(3, 4'b1010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 5'd16, 1'b1);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b100;
        req_addr = 32'h200; req_wdata = 32'h0; req_tag = 5'd17;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_data", rsp_data, 32'hDEADBEEF);
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        ack();
        @(negedge clk);
        chk("hs_req_ready", 32'(req_ready), 32'd1);
        chk("hs_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        await(3, 4'b1100, 32'h200, 32'h0, 32'h00000080, 1'b0, 5'd17, 1'b1);
        ack();

        // reset during the ACCESS cycle of a store
        issue(1'b1, 3'b010, 32'h300, 32'h12345678, 5'd18);
        @(negedge clk);
        chk("abort_access_cmd", 32'(mem_rw_en), 32'hF);
        rst_n = 1'b0;
        #1;
        chk("abort_rw_en", 32'(mem_rw_en), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("abort_mem", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}, 32'h0);
        op(1'b0, 3'b010, 32'h300, 32'h0, 5'd19, 3, 4'b1010, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the data memory.
- Accepts one load/store request from the execute stage over a valid/ready handshake and translates the RISC-V funct3 into the memory's 4-bit READ_WRITE_EN encoding.
- Drives address and write data for exactly one cycle, captures the memory's registered read data, and returns a response (data, destination tag, fault) to writeback over a second valid/ready handshake.

Parameters:
- ADDR_W, 32, address/data width.
- MEM_BYTES, 524288, data-memory size in bytes; any access whose last byte is at or above this faults.
- TAG_W, 5, destination-register tag width.

Ports:
- CLK  input  1  clock.
- RESET_N  input  1  asynchronous active-low reset.
- REQ_VALID  input  1  request valid.
- REQ_READY  output  1  request accepted when high with REQ_VALID.
- REQ_IS_STORE  input  1  1=store, 0=load.
- REQ_FUNCT3  input  3  RISC-V funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW).
- REQ_ADDR  input  ADDR_W  byte address.
- REQ_WDATA  input  ADDR_W  store data.
- REQ_TAG  input  TAG_W  destination register.
- MEM_RW_EN  output  4  memory command.
- MEM_ADDR  output  ADDR_W  memory address.
- MEM_WDATA  output  ADDR_W  memory write data.
- MEM_RDATA  input  ADDR_W  memory read data, valid one cycle after a load command.
- RSP_VALID  output  1  response valid.
- RSP_READY  input  1  consumer ready.
- RSP_DATA  output  ADDR_W  load result; 0 for stores and faults.
- RSP_TAG  output  TAG_W  echoed REQ_TAG.
- RSP_IS_LOAD  output  1  response is from a load (writeback enable).
- RSP_FAULT  output  1  access fault.

Behaviour:
- MEM_RW_EN encoding, bit3 = enable, bits[2:0] = operation:
  - Loads: LB 1000, LH 1001, LW 1010, LBU 1100, LHU 1101.
  - Stores: SB 1011, SH 1110, SW 1111.
  - Idle: 0000.
- The memory already sign/zero-extends read data; the LSU passes MEM_RDATA through unmodified.
- FSM states: IDLE, ACCESS, CAPTURE, RESP.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID, register all request fields and the encoded command, and evaluate fault.
  - Fault → RESP with RSP_FAULT=1 and no memory access.
  - No fault → ACCESS.
- ACCESS (one cycle):
  - MEM_RW_EN = registered command; MEM_ADDR and MEM_WDATA = registered values.
  - Load → CAPTURE; store → RESP.
- CAPTURE (one cycle):
  - MEM_RW_EN = 0000.
  - MEM_RDATA is sampled into RSP_DATA at the end of the cycle, then → RESP.
- RESP:
  - RSP_VALID=1; outputs held stable until RSP_READY=1, then → IDLE.
- Latency: request accepted at edge N:
  - Store: RSP_VALID at N+2.
  - Load: RSP_VALID at N+3.
  - Fault: RSP_VALID at N+1.
- REQ_READY is low in all states except IDLE. A request presented in the same cycle as the RESP→IDLE handshake is accepted on the following cycle. There is no pipelining; one outstanding operation at most.
- MEM_RW_EN is 0000 in every state except ACCESS. It is decoded from state, so it drops asynchronously with RESET_N.
- Fault conditions:
  - Load with funct3 011, 110 or 111.
  - Store with funct3 above 010.
  - REQ_ADDR + size − 1 ≥ MEM_BYTES, evaluated in ADDR_W+1 bits so that wrap-around near 0xFFFFFFFF faults.
  - Misalignment when the optional feature below is enabled.
- Reset values:
  - State IDLE, REQ_READY=1, RSP_VALID=0.
  - RSP_DATA, RSP_TAG, RSP_IS_LOAD and RSP_FAULT all 0.
  - MEM_RW_EN=0000, MEM_ADDR=0, MEM_WDATA=0.
- Reset mid-operation aborts the operation; there is no replay. A store aborted before its ACCESS edge is not written.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined, LH/LHU/SH with ADDR[0]≠0 and LW/SW with ADDR[1:0]≠0 fault with no memory access.
- When undefined, misaligned accesses are passed to memory unchanged, since the memory is byte-addressed.

Decomposition:
- Shared package lsu_pkg holds:
  - state enum;
  - funct3 constants;
  - the eight MEM_RW_EN encodings plus idle;
  - the MEM_BYTES default.
- One combinational sub-module, lsu_cmd_encode: takes is_store, funct3 and addr, and produces rw_en, size and fault. It is reused by the bench's reference model.

Test Plan:
- SW 0xDEADBEEF to 0x100, then LW 0x100 → MEM_RW_EN=1111 for exactly one cycle, then 1010; RSP_DATA=0xDEADBEEF, RSP_IS_LOAD=1, RSP_VALID at N+3.
- SB 0x80 to 0x200, then LB 0x200 and LBU 0x200 → RSP_DATA 0xFFFFFF80, then 0x00000080.
- Load funct3 011, and LW at 0x0007FFFE → RSP_FAULT=1 at N+1, MEM_RW_EN stays 0000 throughout.
- LW at 0x102, with and without LSU_MISALIGN_TRAP_EN → fault, respectively data assembled from bytes 0x102–0x105.
- RSP_READY held low for 5 cycles after a load → RSP_VALID and RSP_DATA stable; REQ_READY=0 with REQ_VALID=1 held; second request accepted the cycle after the handshake.
- RESET_N asserted during ACCESS of an SW → MEM_RW_EN=0000 immediately; memory location unchanged; FSM in IDLE with RSP_VALID=0.
